// File: rtl/user_watchdog_obi.sv
// rtl/user_watchdog_obi.sv - OBI-mapped user watchdog with bark interrupt and bite reset request

package croc_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 2};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  rid;
    logic        err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

module user_watchdog_obi #(
  parameter croc_pkg::obi_cfg_t ObiCfg      = croc_pkg::SbrObiCfg,
  parameter type                obi_req_t   = croc_pkg::sbr_obi_req_t,
  parameter type                obi_rsp_t   = croc_pkg::sbr_obi_rsp_t,
  parameter logic [31:0]        DefaultLoad = 32'h0001_0000
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     wdt_irq_o,
  output logic     wdt_rst_req_o
);

  localparam int unsigned IdWidth = ObiCfg.IdWidth;

  localparam logic [9:0] RegCtrl   = 10'h000;
  localparam logic [9:0] RegLoad   = 10'h001;
  localparam logic [9:0] RegCount  = 10'h002;
  localparam logic [9:0] RegKick   = 10'h003;
  localparam logic [9:0] RegStatus = 10'h004;

  localparam logic [31:0] KickMagic = 32'h5A5A_5A5A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BARKED = 2'd2,
    BITE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic        ctrl_en, ctrl_lock;
  logic [31:0] load_q;
  logic [31:0] count_q, count_d;
  logic        bark_q, bite_q;
  logic        bark_set, bite_set;

  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [IdWidth-1:0] rid_q;

  logic [9:0]  word_sel;
  logic        acc_err;
  logic [31:0] acc_rdata;
  logic        ctrl_we, load_we, kick, w1c;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0]};

  assign word_sel = obi_req_i.a.addr[11:2];

  // Decode the current request into register strobes, read data and error.
  always_comb begin
    acc_err   = 1'b0;
    acc_rdata = 32'h0;
    ctrl_we   = 1'b0;
    load_we   = 1'b0;
    kick      = 1'b0;
    w1c       = 1'b0;
    if (obi_req_i.req) begin
      case (word_sel)
        RegCtrl: begin
          if (obi_req_i.a.we) ctrl_we = ~ctrl_lock;
          else                acc_rdata = {30'h0, ctrl_lock, ctrl_en};
        end
        RegLoad: begin
          if (obi_req_i.a.we) load_we = ~ctrl_lock;
          else                acc_rdata = load_q;
        end
        RegCount: begin
          if (obi_req_i.a.we) acc_err = 1'b1;
          else                acc_rdata = count_q;
        end
        RegKick: begin
          if (obi_req_i.a.we)
            kick = (obi_req_i.a.wdata == KickMagic) && (obi_req_i.a.be == 4'hF);
        end
        RegStatus: begin
          if (obi_req_i.a.we) w1c = obi_req_i.a.wdata[0] & obi_req_i.a.be[0];
          else                acc_rdata = {30'h0, bite_q, bark_q};
        end
        default: acc_err = 1'b1;
      endcase
    end
  end

  // Watchdog next-state and counter logic; a kick beats an expiring count.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    bark_set = 1'b0;
    bite_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en) begin
          state_d = RUN;
          count_d = load_q;
        end
      end
      RUN, BARKED: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (kick) begin
          state_d = RUN;
          count_d = load_q;
        end else if (count_q == 32'h0) begin
          if (state_q == RUN) begin
            bark_set = 1'b1;
            count_d  = load_q;
            state_d  = BARKED;
          end else begin
            bite_set = 1'b1;
            state_d  = BITE;
          end
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      BITE: begin
        count_d = 32'h0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Counter and status flags; a clear never hides a bark raised in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= DefaultLoad;
      bark_q  <= 1'b0;
      bite_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      bark_q  <= bark_set | (bark_q & ~(w1c && (state_q != BITE)));
      bite_q  <= bite_q | bite_set;
    end
  end

  // Byte-wise CTRL and LOAD writes; lock can only be released by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en   <= 1'b0;
      ctrl_lock <= 1'b0;
      load_q    <= DefaultLoad;
    end else begin
      if (ctrl_we && obi_req_i.a.be[0]) begin
        ctrl_en   <= obi_req_i.a.wdata[0];
        ctrl_lock <= obi_req_i.a.wdata[1];
      end
      if (load_we) begin
        for (int i = 0; i < 4; i++) begin
          if (obi_req_i.a.be[i]) load_q[8*i +: 8] <= obi_req_i.a.wdata[8*i +: 8];
        end
      end
    end
  end

  // Response channel: every granted request answers exactly one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= obi_req_i.req;
      if (obi_req_i.req) begin
        rdata_q <= acc_rdata;
        err_q   <= acc_err;
        rid_q   <= obi_req_i.a.aid;
      end
    end
  end

  // Pack the response struct; grant is unconditional.
  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = 1'b1;
    obi_rsp_o.rvalid  = rvalid_q;
    obi_rsp_o.r.rdata = rdata_q;
    obi_rsp_o.r.rid   = rid_q;
    obi_rsp_o.r.err   = err_q;
  end

  assign wdt_irq_o     = bark_q;
  assign wdt_rst_req_o = bite_q;

endmodule

// File: tb/tb_user_watchdog_obi.sv
// tb/tb_user_watchdog_obi.sv - directed self-checking bench for user_watchdog_obi

module tb_user_watchdog_obi;

  localparam logic [31:0] A_CTRL   = 32'h2000_1000;
  localparam logic [31:0] A_LOAD   = 32'h2000_1004;
  localparam logic [31:0] A_COUNT  = 32'h2000_1008;
  localparam logic [31:0] A_KICK   = 32'h2000_100C;
  localparam logic [31:0] A_STATUS = 32'h2000_1010;
  localparam logic [31:0] A_BAD    = 32'h2000_1020;
  localparam logic [31:0] KICK_VAL = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  croc_pkg::sbr_obi_req_t req = '0;
  croc_pkg::sbr_obi_rsp_t rsp;
  logic irq, rst_req;

  int checks = 0;
  int errors = 0;

  logic        rv, er;
  logic [31:0] rdat;
  logic [1:0]  ri;

  user_watchdog_obi dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .obi_req_i    (req),
    .obi_rsp_o    (rsp),
    .wdt_irq_o    (irq),
    .wdt_rst_req_o(rst_req)
  );

  always #5 clk = ~clk;

  task automatic bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [1:0] aid);
    req.req     = 1'b1;
    req.a.addr  = addr;
    req.a.we    = we;
    req.a.be    = be;
    req.a.wdata = wdata;
    req.a.aid   = aid;
    @(posedge clk);
    #1;
    req.req = 1'b0;
    rv   = rsp.rvalid;
    er   = rsp.r.err;
    rdat = rsp.r.rdata;
    ri   = rsp.r.rid;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(addr, 1'b1, 4'hF, data, 2'd0);
  endtask

  task automatic rd(input logic [31:0] addr);
    bus(addr, 1'b0, 4'hF, 32'h0, 2'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({rsp.gnt, rsp.rvalid, rsp.r.err, rsp.r.rid, rsp.r.rdata, irq, rst_req} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b rvalid=%b err=%b rid=%0d rdata=%h irq=%b rst_req=%b, expected 1 0 0 0 0 0 0",
               rsp.gnt, rsp.rvalid, rsp.r.err, rsp.r.rid, rsp.r.rdata, irq, rst_req);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(A_CTRL);
    checks++;
    if ({rv, er, ri, rdat} !== {1'b1, 1'b0, 2'd1, 32'h0}) begin
      errors++; $display("FAIL reset_ctrl: got rv=%b err=%b rid=%0d rdata=%h, expected 1 0 1 0", rv, er, ri, rdat);
    end
    rd(A_LOAD);
    checks++;
    if ({er, rdat} !== {1'b0, 32'h0001_0000}) begin
      errors++; $display("FAIL reset_load: got err=%b rdata=%h, expected 0 00010000", er, rdat);
    end
    rd(A_COUNT);
    checks++;
    if ({er, rdat} !== {1'b0, 32'h0001_0000}) begin
      errors++; $display("FAIL reset_count: got err=%b rdata=%h, expected 0 00010000", er, rdat);
    end
    rd(A_STATUS);
    checks++;
    if ({er, rdat} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_status: got err=%b rdata=%h, expected 0 0", er, rdat);
    end
    rd(A_KICK);
    checks++;
    if ({er, rdat} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL kick_reads_zero: got err=%b rdata=%h, expected 0 0", er, rdat);
    end
  endtask

  task automatic test_bark_bite();
    wr(A_LOAD, 32'd10);
    wr(A_CTRL, 32'h1);
    idle(11);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL bark_early: got irq=%b expected 0", irq); end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL bark_time: got irq=%b expected 1", irq); end
    idle(10);
    checks++;
    if (rst_req !== 1'b0) begin errors++; $display("FAIL bite_early: got rst_req=%b expected 0", rst_req); end
    idle(1);
    checks++;
    if ({rst_req, irq} !== 2'b11) begin errors++; $display("FAIL bite_time: got rst_req=%b irq=%b expected 1 1", rst_req, irq); end
    wr(A_KICK, KICK_VAL);
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h0);
    idle(3);
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'h0) begin errors++; $display("FAIL bite_count_zero: got %h expected 0", rdat); end
    rd(A_STATUS);
    checks++;
    if ({rdat, rst_req} !== {32'h3, 1'b1}) begin
      errors++; $display("FAIL bite_sticky: got status=%h rst_req=%b expected 3 1", rdat, rst_req);
    end
  endtask

  task automatic test_reset_in_bite();
    req.req = 1'b1; req.a.addr = A_BAD; req.a.we = 1'b0; req.a.be = 4'hF; req.a.wdata = 32'h0; req.a.aid = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp.gnt, rsp.rvalid, rsp.r.err, rsp.r.rid, rsp.r.rdata, irq, rst_req} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_in_bite: got gnt=%b rvalid=%b err=%b rid=%0d rdata=%h irq=%b rst_req=%b, expected 1 0 0 0 0 0 0",
               rsp.gnt, rsp.rvalid, rsp.r.err, rsp.r.rid, rsp.r.rdata, irq, rst_req);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    req.req = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp.rvalid !== 1'b0) begin errors++; $display("FAIL inflight_dropped: got rvalid=%b expected 0", rsp.rvalid); end
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'h0001_0000) begin errors++; $display("FAIL post_reset_count: got %h expected 00010000", rdat); end
  endtask

  task automatic test_kick_periodic();
    wr(A_LOAD, 32'd10);
    wr(A_CTRL, 32'h1);
    for (int k = 0; k < 12; k++) begin
      wr(A_KICK, KICK_VAL);
      for (int j = 1; j <= 7; j++) begin
        rd(A_COUNT);
        checks++;
        if (rdat !== 32'(11 - j) || rdat < 32'd2) begin
          errors++; $display("FAIL kick_count k=%0d j=%0d: got %0d expected %0d", k, j, rdat, 11 - j);
        end
      end
      checks++;
      if ({irq, rst_req} !== 2'b00) begin
        errors++; $display("FAIL kick_no_bark k=%0d: got irq=%b rst_req=%b expected 0 0", k, irq, rst_req);
      end
    end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_kick_at_zero();
    wr(A_CTRL, 32'h1);
    idle(10);
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'd1) begin errors++; $display("FAIL zero_pre_count: got %0d expected 1", rdat); end
    wr(A_KICK, KICK_VAL);
    rd(A_COUNT);
    checks++;
    if ({rdat, irq} !== {32'd10, 1'b0}) begin
      errors++; $display("FAIL kick_on_zero: got count=%0d irq=%b expected 10 0", rdat, irq);
    end
    wr(A_KICK, 32'h0000_1234);
    checks++;
    if ({rv, er} !== 2'b10) begin errors++; $display("FAIL bad_kick_resp: got rv=%b err=%b expected 1 0", rv, er); end
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'd8) begin errors++; $display("FAIL bad_kick_ignored: got %0d expected 8", rdat); end
    idle(10);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL bark_after_bad_kick: got irq=%b expected 1", irq); end
    rd(A_STATUS);
    wr(A_KICK, KICK_VAL);
    rd(A_STATUS);
    checks++;
    if (rdat !== 32'h1) begin errors++; $display("FAIL bark_survives_kick: got %h expected 1", rdat); end
    wr(A_STATUS, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clears: got irq=%b expected 0", irq); end
    rd(A_STATUS);
    idle(7);
    wr(A_STATUS, 32'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_vs_new_bark: got irq=%b expected 1", irq); end
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_after_disable: got irq=%b expected 0", irq); end
  endtask

  task automatic test_byte_enable();
    bus(A_LOAD, 1'b1, 4'hF, 32'hAABB_CCDD, 2'd0);
    bus(A_LOAD, 1'b1, 4'b0101, 32'h1122_3344, 2'd0);
    rd(A_LOAD);
    checks++;
    if (rdat !== 32'hAA22_CC44) begin errors++; $display("FAIL load_byte_en: got %h expected aa22cc44", rdat); end
    bus(A_CTRL, 1'b1, 4'b1110, 32'h3, 2'd0);
    rd(A_CTRL);
    checks++;
    if (rdat !== 32'h0) begin errors++; $display("FAIL ctrl_byte_en: got %h expected 0", rdat); end
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'd9) begin errors++; $display("FAIL idle_count_held: got %0d expected 9", rdat); end
  endtask

  task automatic test_lock();
    wr(A_LOAD, 32'd10);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h3);
    wr(A_LOAD, 32'd5);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL locked_load_err: got err=%b expected 0", er); end
    wr(A_CTRL, 32'h0);
    rd(A_CTRL);
    checks++;
    if (rdat !== 32'h3) begin errors++; $display("FAIL locked_ctrl: got %h expected 3", rdat); end
    rd(A_LOAD);
    checks++;
    if (rdat !== 32'd10) begin errors++; $display("FAIL locked_load: got %0d expected 10", rdat); end
    wr(A_KICK, KICK_VAL);
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'd10) begin errors++; $display("FAIL locked_run_a: got %0d expected 10", rdat); end
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'd9) begin errors++; $display("FAIL locked_run_b: got %0d expected 9", rdat); end
  endtask

  task automatic test_errors();
    bus(A_BAD, 1'b0, 4'hF, 32'h0, 2'd3);
    checks++;
    if ({rv, er, ri, rdat} !== {1'b1, 1'b1, 2'd3, 32'h0}) begin
      errors++; $display("FAIL unmapped_read: got rv=%b err=%b rid=%0d rdata=%h expected 1 1 3 0", rv, er, ri, rdat);
    end
    idle(1);
    checks++;
    if (rsp.rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_single: got %b expected 0", rsp.rvalid); end
    bus(A_COUNT, 1'b1, 4'hF, 32'h55, 2'd2);
    checks++;
    if ({rv, er, ri, rdat} !== {1'b1, 1'b1, 2'd2, 32'h0}) begin
      errors++; $display("FAIL count_write_err: got rv=%b err=%b rid=%0d rdata=%h expected 1 1 2 0", rv, er, ri, rdat);
    end
  endtask

  task automatic test_load_zero();
    apply_reset();
    wr(A_LOAD, 32'h0);
    wr(A_CTRL, 32'h1);
    idle(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL load0_no_bark_yet: got irq=%b expected 0", irq); end
    idle(1);
    checks++;
    if ({irq, rst_req} !== 2'b10) begin errors++; $display("FAIL load0_bark: got irq=%b rst_req=%b expected 1 0", irq, rst_req); end
    idle(1);
    checks++;
    if (rst_req !== 1'b1) begin errors++; $display("FAIL load0_bite: got rst_req=%b expected 1", rst_req); end
    rd(A_COUNT);
    checks++;
    if (rdat !== 32'h0) begin errors++; $display("FAIL load0_count: got %h expected 0", rdat); end
  endtask

  initial begin
    test_reset();
    test_bark_bite();
    test_reset_in_bite();
    test_kick_periodic();
    test_kick_at_zero();
    test_byte_enable();
    test_lock();
    test_errors();
    test_load_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
